mdu_iterative: RTL and testbench

- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers of the MIPS core.
- Accepts mult/multu/div/divu requests from the execute stage over a valid/ready handshake and iterates one bit per cycle.
- Writes a 64-bit result to HI/LO and pulses done; the pipeline stalls mfhi/mflo while busy is high.
- Opcodes match the core's existing ALU control codes.

---
 rtl/mdu_if.sv | 28 ++
 rtl/mdu_iterative.sv | 169 ++++++++++++++++
 tb/tb_mdu_iterative.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// mdu_if: request/response bundle between the execute stage and the
// multiply/divide unit, including the mthi/mtlo write port and HI/LO readback.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic             op_ready;
  logic [5:0]       op_code;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi_en;
  logic             mtlo_en;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op_code, a, b, mthi_en, mtlo_en, wdata,
    input  op_ready, busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op_code, a, b, mthi_en, mtlo_en, wdata,
    output op_ready, busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iterative.sv
// mdu_iterative: one-bit-per-cycle multiply/divide unit owning HI/LO.
// Signed and unsigned mult/div work on magnitudes; a single FIX cycle
// applies sign correction and writes HI/LO while pulsing done.
// Optional build macro MDU_FAST_MULT_EN: mult/multu skip the iterative
// phase and produce their product in the cycle after acceptance.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [5:0] OP_MULT  = 6'd15;
  localparam logic [5:0] OP_MULTU = 6'd16;
  localparam logic [5:0] OP_DIV   = 6'd17;
  localparam logic [5:0] OP_DIVU  = 6'd18;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;      // mult: {partial hi, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   araw_q, araw_d;    // dividend as presented, for divide-by-zero
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               legal_s, is_signed_s, is_div_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;

  assign legal_s     = (bus.op_code == OP_MULT) || (bus.op_code == OP_MULTU) ||
                       (bus.op_code == OP_DIV)  || (bus.op_code == OP_DIVU);
  assign is_signed_s = (bus.op_code == OP_MULT) || (bus.op_code == OP_DIV);
  assign is_div_s    = (bus.op_code == OP_DIV)  || (bus.op_code == OP_DIVU);
  assign mag_a_s     = (is_signed_s && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b_s     = (is_signed_s && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Shift-add step: conditionally add multiplicand into the upper half, then shift right.
  assign mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                       (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  // Restoring step: bring in next dividend bit and trial-subtract the divisor.
  assign div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opnd_q};

`ifdef MDU_FAST_MULT_EN
  assign prod_s = is_div_q ? acc_q :
                  ({{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]});
`else
  assign prod_s = acc_q;
`endif
  assign prod_fix_s = neg_res_q ? -prod_s : prod_s;

  // Next-state, datapath iteration and HI/LO update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    araw_d    = araw_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.mthi_en) hi_d = bus.wdata;
        else             hi_d = hi_q;
        if (bus.mtlo_en) lo_d = bus.wdata;
        else             lo_d = lo_q;
        if (bus.op_valid && legal_s) begin
          opnd_d    = is_div_s ? mag_b_s : mag_a_s;
          acc_d     = {{WIDTH{1'b0}}, (is_div_s ? mag_a_s : mag_b_s)};
          araw_d    = bus.a;
          is_div_d  = is_div_s;
          neg_res_d = is_signed_s && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_rem_d = is_signed_s && bus.a[WIDTH-1];
          cnt_d     = {CW{1'b0}};
          state_d   = S_CALC;
`ifdef MDU_FAST_MULT_EN
          if (!is_div_s) state_d = S_FIX;
          else           state_d = S_CALC;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          if (!div_diff_s[WIDTH]) acc_d = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                    acc_d = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        else                         state_d = S_CALC;
      end
      S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
          lo_d = prod_fix_s[WIDTH-1:0];
        end else if (opnd_q == {WIDTH{1'b0}}) begin
          hi_d = araw_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      opnd_q    <= {WIDTH{1'b0}};
      araw_q    <= {WIDTH{1'b0}};
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      araw_q    <= araw_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.op_ready = ~busy_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed vectors with a scoreboard; the stimulus process
// queues expected HI/LO and latency on acceptance, a monitor checks each done.
module tb_mdu_iterative;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(32)) bus();
  mdu_iterative #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse is matched against the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      chk("done_single_cycle", {63'd0, prev_done}, 64'd0);
      chk("busy_low_in_done", {63'd0, bus.busy}, 64'd0);
      chk("ready_in_done", {63'd0, bus.op_ready}, 64'd1);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no pending op (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("result_hi", {32'd0, bus.hi}, {32'd0, mon_e.hi});
        chk("result_lo", {32'd0, bus.lo}, {32'd0, mon_e.lo});
        chk("latency", 64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
      end
    end
    prev_done <= bus.done;
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                       output logic done_at_acc, output int waits);
    exp_t e;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.a        = aa;
    bus.b        = bb;
    waits = 0;
    while (bus.op_ready !== 1'b1 && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    done_at_acc = bus.done;
    if (bus.op_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got op_ready=%b, expected 1 within 100 cycles", bus.op_ready);
    end else begin
      e.hi = ehi;
      e.lo = elo;
      e.acc_cyc = cyc + 1;
      e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op_code  = 6'd0;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%b, expected 0 within 200 cycles", bus.busy);
    end
  endtask

  initial begin
    logic da;
    int   w;
    bus.op_valid = 1'b0;
    bus.op_code  = 6'd0;
    bus.a        = 32'd0;
    bus.b        = 32'd0;
    bus.mthi_en  = 1'b0;
    bus.mtlo_en  = 1'b0;
    bus.wdata    = 32'd0;
    reset        = 1'b1;
    #3;
    chk("reset_hi", {32'd0, bus.hi}, 64'd0);
    chk("reset_lo", {32'd0, bus.lo}, 64'd0);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_done", {63'd0, bus.done}, 64'd0);
    chk("reset_ready", {63'd0, bus.op_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // Signed and unsigned multiply.
    issue(6'd15, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT, da, w);
    wait_idle();
    issue(6'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, da, w);
    wait_idle();
    // Signed/unsigned divide of the same operands.
    issue(6'd17, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, da, w);
    wait_idle();
    issue(6'd18, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, DIV_LAT, da, w);
    wait_idle();
    // Divide by zero and signed overflow.
    issue(6'd18, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, DIV_LAT, da, w);
    wait_idle();
    issue(6'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT, da, w);
    wait_idle();

    // mtlo in IDLE, then both enables together.
    @(negedge clk);
    bus.mtlo_en = 1'b1;
    bus.wdata   = 32'h0000_5555;
    @(negedge clk);
    bus.mtlo_en = 1'b0;
    chk("mtlo_lo", {32'd0, bus.lo}, 64'h5555);
    chk("mtlo_hi_kept", {32'd0, bus.hi}, 64'd0);
    bus.mthi_en = 1'b1;
    bus.mtlo_en = 1'b1;
    bus.wdata   = 32'h1234_5678;
    @(negedge clk);
    bus.mthi_en = 1'b0;
    bus.mtlo_en = 1'b0;
    chk("mt_both_hi", {32'd0, bus.hi}, 64'h1234_5678);
    chk("mt_both_lo", {32'd0, bus.lo}, 64'h1234_5678);

    // mthi during busy is ignored; a second request is held until the done cycle.
    issue(6'd17, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFF2, DIV_LAT, da, w);
    @(negedge clk);
    bus.mthi_en = 1'b1;
    bus.wdata   = 32'h0000_AAAA;
    @(negedge clk);
    bus.mthi_en = 1'b0;
    chk("mthi_busy_ignored", {32'd0, bus.hi}, 64'h1234_5678);
    chk("busy_during_calc", {63'd0, bus.busy}, 64'd1);
    chk("ready_during_calc", {63'd0, bus.op_ready}, 64'd0);
    issue(6'd18, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, DIV_LAT, da, w);
    chk("held_request_waited", {63'd0, (w > 0)}, 64'd1);
    chk("accept_in_done_cycle", {63'd0, da}, 64'd1);
    wait_idle();

    // Illegal op code: nothing starts, HI/LO untouched.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = 6'd20;
    bus.a        = 32'd9;
    bus.b        = 32'd3;
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op_code  = 6'd0;
    chk("illegal_no_busy", {63'd0, bus.busy}, 64'd0);
    chk("illegal_hi_kept", {32'd0, bus.hi}, 64'd2);
    chk("illegal_lo_kept", {32'd0, bus.lo}, 64'd14);

    // Reset in the middle of a divide aborts it.
    issue(6'd17, 32'd1000, 32'd3, 32'd1, 32'd333, DIV_LAT, da, w);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    void'(sb.pop_back());
    chk("abort_hi", {32'd0, bus.hi}, 64'd0);
    chk("abort_lo", {32'd0, bus.lo}, 64'd0);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_done", {63'd0, bus.done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(6'd16, 32'd3, 32'd4, 32'd0, 32'd12, MUL_LAT, da, w);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
